mem_responder: RTL and testbench

Memory-side responder for the Riscv141 core's instruction and data ports: it accepts the core's per-cycle icache/dcache accesses, serializes them onto one single-ported backing-memory request/response channel, returns read data on `icache_dout`/`dcache_dout`, and holds `stall` high until the cycle's accesses are complete. It sits between the core and the shared backing memory, one instance per core.

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for one Riscv141 core. It takes the core's
//   instruction and data accesses for one cycle, issues them one at a time
//   on a single backing-memory channel (instruction first), and holds the
//   core stalled until every captured access has completed.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   icache_*         core instruction port (byte address, read enable, data)
//   dcache_*         core data port (byte address, read enable, byte-lane
//                    write enables, write data, read data)
//   stall            high while a captured access set is being serviced
//   mem_req_*        backing-memory request channel (valid/ready handshake)
//   mem_resp_*       backing-memory read response (no response for writes)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access in service; capture new accesses here
// IREQ  | instruction read request presented, waiting for ready
// IRESP | instruction read accepted, waiting for response data
// DREQ  | data read/write request presented, waiting for ready
// DRESP | data read accepted, waiting for response data
module mem_responder #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       icache_addr,
    input  logic              icache_re,
    output logic [31:0]       icache_dout,
    input  logic [31:0]       dcache_addr,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_data,
    output logic [3:0]        mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        IRESP = 3'd2,
        DREQ  = 3'd3,
        DRESP = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [31:0]       d_din_q;
    logic [3:0]        d_we_q;
    logic              i_pend;
    logic              d_pend;
    logic              d_wr;

    logic any_req;
    logic d_req_in;
    logic handshake;

    assign d_req_in  = dcache_re | (|dcache_we);
    assign any_req   = icache_re | d_req_in;
    assign handshake = mem_req_valid & mem_req_ready;

    // Byte-offset bits and bits above the backing word address are dropped.
    // i_pend is held as a record of the captured set; routing is decided at
    // capture time from the live request, so nothing downstream reads it.
    logic unused_bits;
    assign unused_bits = ^{icache_addr[31:ADDR_W+2], icache_addr[1:0],
                           dcache_addr[31:ADDR_W+2], dcache_addr[1:0], i_pend};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            d_din_q     <= '0;
            d_we_q      <= '0;
            i_pend      <= 1'b0;
            d_pend      <= 1'b0;
            d_wr        <= 1'b0;
            icache_dout <= '0;
            dcache_dout <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                i_addr_q <= icache_addr[ADDR_W+1:2];
                d_addr_q <= dcache_addr[ADDR_W+1:2];
                d_din_q  <= dcache_din;
                d_we_q   <= dcache_we;
                i_pend   <= icache_re;
                d_pend   <= d_req_in;
                d_wr     <= |dcache_we;
            end
            if (state == IRESP && mem_resp_valid) begin
                icache_dout <= mem_resp_data;
            end
            if (state == DRESP && mem_resp_valid) begin
                dcache_dout <= mem_resp_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = icache_re ? IREQ : DREQ;
                end
            end
            IREQ: begin
                if (handshake) begin
                    state_nxt = IRESP;
                end
            end
            IRESP: begin
                if (mem_resp_valid) begin
                    state_nxt = d_pend ? DREQ : IDLE;
                end
            end
            DREQ: begin
                if (handshake) begin
                    state_nxt = d_wr ? IDLE : DRESP;
                end
            end
            DRESP: begin
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields come straight from captured registers, so they cannot
    // move while a request waits for ready.
    logic d_phase;
    assign d_phase = (state == DREQ);

    assign stall         = (state != IDLE);
    assign mem_req_valid = (state == IREQ) || d_phase;
    assign mem_req_rw    = d_phase && d_wr;
    assign mem_req_addr  = d_phase ? d_addr_q : i_addr_q;
    assign mem_req_data  = (d_phase && d_wr) ? d_din_q : 32'h0;
    assign mem_req_mask  = (d_phase && d_wr) ? d_we_q  : 4'h0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] icache_addr = 32'h0;
    logic        icache_re = 1'b0;
    logic [31:0] icache_dout;
    logic [31:0] dcache_addr = 32'h0;
    logic        dcache_re = 1'b0;
    logic [3:0]  dcache_we = 4'h0;
    logic [31:0] dcache_din = 32'h0;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_req_rw;
    logic [13:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    // backing memory model
    logic [31:0] mem [0:16383];
    logic        m_valid;
    logic [31:0] m_data;
    logic [31:0] resp_buf;
    int          resp_cnt;
    int          resp_lat = 1;   // 1 = response in the cycle right after handshake
    logic        stray_v = 1'b0;
    logic [31:0] stray_d = 32'h0;
    logic [18:0] req_log [$];    // {rw, mask, addr}

    int tests = 0;
    int fails = 0;

    assign mem_resp_valid = m_valid | stray_v;
    assign mem_resp_data  = stray_v ? stray_d : m_data;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(14)) dut (
        .clk           (clk),
        .reset         (reset),
        .icache_addr   (icache_addr),
        .icache_re     (icache_re),
        .icache_dout   (icache_dout),
        .dcache_addr   (dcache_addr),
        .dcache_re     (dcache_re),
        .dcache_we     (dcache_we),
        .dcache_din    (dcache_din),
        .dcache_dout   (dcache_dout),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_valid        <= 1'b0;
            m_data         <= 32'h0;
            resp_cnt       <= 0;
            mem[14'h800]   <= 32'h00000013;
            mem[14'h801]   <= 32'h12345678;
            mem[14'h401]   <= 32'hDEADBEEF;
        end else begin
            m_valid <= 1'b0;
            if (resp_cnt == 1) begin
                m_valid  <= 1'b1;
                m_data   <= resp_buf;
                resp_cnt <= 0;
            end else if (resp_cnt > 1) begin
                resp_cnt <= resp_cnt - 1;
            end
            if (mem_req_valid && mem_req_ready) begin
                req_log.push_back({mem_req_rw, mem_req_mask, mem_req_addr});
                if (mem_req_rw) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_req_mask[b])
                            mem[mem_req_addr][8*b +: 8] <= mem_req_data[8*b +: 8];
                end else if (resp_lat == 1) begin
                    m_valid <= 1'b1;
                    m_data  <= mem[mem_req_addr];
                end else begin
                    resp_buf <= mem[mem_req_addr];
                    resp_cnt <= resp_lat - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        icache_re = 1'b0;
        dcache_re = 1'b0;
        dcache_we = 4'h0;
    endtask

    task automatic run_until_idle(output int n);
        n = 0;
        while (stall && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(stall), 32'h0);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [18:0] exp);
        logic [18:0] got;
        got = (idx < req_log.size()) ? req_log[idx] : 19'h7FFFF;
        chk(tag, 32'(got), 32'(exp));
    endtask

    int n;

    initial begin
        // reset with all requests driven
        icache_re = 1'b1; icache_addr = 32'h2000;
        dcache_re = 1'b1; dcache_addr = 32'h1004;
        reset = 1'b1;
        tick(); tick();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_rw", 32'(mem_req_rw), 32'h0);
        chk("rst_addr", 32'(mem_req_addr), 32'h0);
        chk("rst_data", mem_req_data, 32'h0);
        chk("rst_mask", 32'(mem_req_mask), 32'h0);
        chk("rst_idout", icache_dout, 32'h0);
        chk("rst_ddout", dcache_dout, 32'h0);

        // I+D read, captured on the first edge after reset
        reset = 1'b0;
        tick();
        clear_req();
        chk("rd_cap_stall", 32'(stall), 32'h1);
        chk("rd_cap_addr", 32'(mem_req_addr), 32'h800);
        run_until_idle(n);
        chk("rd_stall_cycles", 32'(n), 32'd4);
        chk("rd_idout", icache_dout, 32'h00000013);
        chk("rd_ddout", dcache_dout, 32'hDEADBEEF);
        chk_log("rd_req0", 0, {1'b0, 4'h0, 14'h800});
        chk_log("rd_req1", 1, {1'b0, 4'h0, 14'h401});
        req_log.delete();

        // I read + byte write to lane 2
        icache_re = 1'b1; icache_addr = 32'h2000;
        dcache_we = 4'b0100; dcache_din = 32'h00AB0000; dcache_addr = 32'h1006;
        tick();
        clear_req();
        run_until_idle(n);
        chk("bw_stall_cycles", 32'(n), 32'd3);
        chk_log("bw_req0", 0, {1'b0, 4'h0, 14'h800});
        chk_log("bw_req1", 1, {1'b1, 4'b0100, 14'h401});
        chk("bw_mem", mem[14'h401], 32'hDEABBEEF);
        chk("bw_ddout", dcache_dout, 32'hDEADBEEF);
        req_log.delete();

        // data write only, lane 0
        dcache_we = 4'b0001; dcache_din = 32'h00000055; dcache_addr = 32'h1004;
        tick();
        clear_req();
        run_until_idle(n);
        chk("dw_stall_cycles", 32'(n), 32'd1);
        chk("dw_mem", mem[14'h401], 32'hDEABBE55);
        chk_log("dw_req0", 0, {1'b1, 4'b0001, 14'h401});
        req_log.delete();

        // backpressure: ready low 5 cycles in IREQ, I response 3 cycles after handshake
        mem_req_ready = 1'b0;
        resp_lat = 3;
        icache_re = 1'b1; icache_addr = 32'h2000;
        dcache_re = 1'b1; dcache_addr = 32'h1004;
        tick();
        clear_req();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(mem_req_valid), 32'h1);
            chk("bp_addr", 32'(mem_req_addr), 32'h800);
            chk("bp_rw", 32'(mem_req_rw), 32'h0);
            chk("bp_mask", 32'(mem_req_mask), 32'h0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        resp_lat = 1;
        run_until_idle(n);
        chk("bp_stall_cycles", 32'(n + 6), 32'd11);
        chk("bp_idout", icache_dout, 32'h00000013);
        chk("bp_ddout", dcache_dout, 32'hDEABBE55);
        req_log.delete();

        // stray response in IDLE
        stray_v = 1'b1; stray_d = 32'hBAD0BAD0;
        tick();
        stray_v = 1'b0;
        chk("stray_idle_stall", 32'(stall), 32'h0);
        chk("stray_idle_idout", icache_dout, 32'h00000013);
        chk("stray_idle_ddout", dcache_dout, 32'hDEABBE55);

        // stray response in IREQ
        mem_req_ready = 1'b0;
        icache_re = 1'b1; icache_addr = 32'h2004;
        tick();
        clear_req();
        stray_v = 1'b1;
        tick();
        stray_v = 1'b0;
        chk("stray_ireq_stall", 32'(stall), 32'h1);
        chk("stray_ireq_valid", 32'(mem_req_valid), 32'h1);
        chk("stray_ireq_addr", 32'(mem_req_addr), 32'h801);
        chk("stray_ireq_idout", icache_dout, 32'h00000013);
        mem_req_ready = 1'b1;
        run_until_idle(n);
        chk("ionly_stall_cycles", 32'(n), 32'd2);
        chk("ionly_idout", icache_dout, 32'h12345678);
        req_log.delete();

        // reset while waiting in DRESP
        icache_re = 1'b1; icache_addr = 32'h2000;
        dcache_re = 1'b1; dcache_addr = 32'h1004;
        tick();
        clear_req();
        tick();
        resp_lat = 3;
        tick();
        tick();
        chk("mid_dresp_stall", 32'(stall), 32'h1);
        chk("mid_dresp_ddout", dcache_dout, 32'hDEABBE55);
        reset = 1'b1;
        tick();
        chk("mid_rst_stall", 32'(stall), 32'h0);
        chk("mid_rst_valid", 32'(mem_req_valid), 32'h0);
        chk("mid_rst_ddout", dcache_dout, 32'h0);
        chk("mid_rst_idout", icache_dout, 32'h0);
        reset = 1'b0;
        stray_v = 1'b1; stray_d = 32'hFFFF0000;
        tick();
        stray_v = 1'b0;
        chk("late_resp_ddout", dcache_dout, 32'h0);
        chk("late_resp_stall", 32'(stall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
